// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM primitive test harnesses (write side and read side).
package lutram_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lt_state_e;

    localparam logic [1:0] PAT_ZERO   = 2'd0;
    localparam logic [1:0] PAT_ADDR0  = 2'd1;
    localparam logic [1:0] PAT_NADDR0 = 2'd2;
    localparam logic [1:0] PAT_PARITY = 2'd3;

    // Address is passed zero-extended; zero bits do not disturb the parity reduction.
    function automatic logic expected_bit(input logic [1:0] pattern, input logic [31:0] addr);
        logic bit_v;
        case (pattern)
            PAT_ZERO:   bit_v = 1'b0;
            PAT_ADDR0:  bit_v = addr[0];
            PAT_NADDR0: bit_v = ~addr[0];
            default:    bit_v = ^addr;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/lutram_expect_pipe.sv
// Delay line aligning issued address and expected bits with the RAM read data.
module lutram_expect_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lutram_readback_checker.sv
// Sweeps both LUTRAM read ports, compares against the write-side pattern and
// reports pass/fail, mismatch count and the first failing location.
module lutram_readback_checker
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH      = 5,
    parameter int READ_LATENCY = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         pattern_i,
    input  logic [A_WIDTH-1:0] dp_offset_i,
    output logic [A_WIDTH-1:0] a_o,
    output logic [A_WIDTH-1:0] dpra_o,
    input  logic               spo_i,
    input  logic               dpo_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [A_WIDTH+1:0] err_count_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic               first_err_port_o
);

    localparam int CW = A_WIDTH + 2;
    localparam int PW = 2 * A_WIDTH + 3;
    localparam logic [A_WIDTH-1:0] ADDR_MAX = '1;

    lt_state_e          state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]         pattern_q, pattern_d;
    logic [A_WIDTH-1:0] offset_q, offset_d;
    logic [1:0]         drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CW-1:0]      err_count_q, err_count_d;
    logic               found_q, found_d;
    logic [A_WIDTH-1:0] first_addr_q, first_addr_d;
    logic               first_port_q, first_port_d;

    logic [A_WIDTH-1:0] dpra;
    logic               exp_spo, exp_dpo;
    logic [PW-1:0]      pipe_in, pipe_out;
    logic               p_valid, p_exp_spo, p_exp_dpo;
    logic [A_WIDTH-1:0] p_a, p_dpra;
    logic               spo_mis, dpo_mis;

    assign dpra    = addr_q + offset_q;
    assign exp_spo = expected_bit(pattern_q, 32'(addr_q));
    assign exp_dpo = expected_bit(pattern_q, 32'(dpra));
    assign pipe_in = {state_q == ST_ISSUE, addr_q, dpra, exp_spo, exp_dpo};

    lutram_expect_pipe #(
        .WIDTH (PW),
        .DEPTH (READ_LATENCY)
    ) u_expect_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    assign p_valid   = pipe_out[PW-1];
    assign p_a       = pipe_out[PW-2 -: A_WIDTH];
    assign p_dpra    = pipe_out[A_WIDTH+1 -: A_WIDTH];
    assign p_exp_spo = pipe_out[1];
    assign p_exp_dpo = pipe_out[0];

    assign spo_mis = p_valid && (spo_i != p_exp_spo);
    assign dpo_mis = p_valid && (dpo_i != p_exp_dpo);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pattern_d    = pattern_q;
        offset_d     = offset_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q + CW'(spo_mis) + CW'(dpo_mis);
        found_d      = found_q;
        first_addr_d = first_addr_q;
        first_port_d = first_port_q;

        // SPO wins when both ports miss in the same cycle.
        if (!found_q && (spo_mis || dpo_mis)) begin
            found_d      = 1'b1;
            first_addr_d = spo_mis ? p_a : p_dpra;
            first_port_d = !spo_mis;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d      = ST_ISSUE;
                    addr_d       = '0;
                    pattern_d    = pattern_i;
                    offset_d     = dp_offset_i;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    found_d      = 1'b0;
                    first_addr_d = '0;
                    first_port_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                    drain_d = 2'(READ_LATENCY);
                end else begin
                    addr_d = addr_q + A_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            pattern_q    <= '0;
            offset_q     <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            found_q      <= 1'b0;
            first_addr_q <= '0;
            first_port_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pattern_q    <= pattern_d;
            offset_q     <= offset_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            found_q      <= found_d;
            first_addr_q <= first_addr_d;
            first_port_q <= first_port_d;
        end
    end

    assign a_o              = addr_q;
    assign dpra_o           = dpra;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_addr_q;
    assign first_err_port_o = first_port_q;

endmodule
